gray_encoder: RTL and testbench
===============================

Name: gray_encoder

Overview:
- Binary-to-reflected-Gray encoder with two outputs: a combinational Gray output (zero latency) and a registered copy with a valid flag.
- A built-in round-trip checker decodes the registered Gray value back to binary and flags any mismatch.
- Sits between binary counters/pointers and clock-domain-crossing or position-encoding logic.

Parameters:
- WIDTH, 4, bit width of the binary input and Gray outputs (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- bin  input  WIDTH  binary value to encode.
- en  input  1  when high, capture the encoding of bin into the register stage on the next clk edge.
- gray  output  WIDTH  combinational Gray code of bin.
- gray_q  output  WIDTH  registered Gray code.
- out_valid  output  1  gray_q holds a value captured since reset.
- chk_err  output  1  registered round-trip mismatch flag (sticky).

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Combinational path:
  - gray[WIDTH-1] = bin[WIDTH-1].
  - gray[i] = bin[i+1] XOR bin[i] for i = 0..WIDTH-2.
  - Equivalently, gray = bin XOR (bin >> 1), logical shift.
  - Purely combinational and independent of clk, rst_n and en. It is valid in the same delta as bin changes, including while in reset.
- Register stage, on rising clk with rst_n high:
  - If en = 1: gray_q <= gray and out_valid <= 1.
  - If en = 0: gray_q and out_valid hold.
- Latency: gray_q reflects bin one cycle after the en cycle.
- Round-trip checker:
  - Sub-module gray_decode computes bin_rt from gray_q, with bin_rt[WIDTH-1] = gray_q[WIDTH-1] and bin_rt[i] = bin_rt[i+1] XOR gray_q[i].
  - A register bin_d captures bin on every en cycle.
  - On any clk edge where out_valid = 1 and bin_rt != bin_d, chk_err <= 1.
  - chk_err remains set until reset and is not cleared by en.
- Reset (rst_n low, asynchronous): gray_q = 0, out_valid = 0, chk_err = 0, bin_d = 0 immediately, without waiting for a clock edge.
- Reset deassertion: registers start updating on the first rising edge after rst_n goes high.
- Reset mid-operation: any pending capture is discarded, and out_valid drops to 0 at once.
- Boundaries:
  - bin = 0 gives gray = 0.
  - bin = all-ones gives gray = 1 followed by WIDTH-1 zeros (WIDTH=4: 1000).
  - Wrap-around from all-ones to 0 changes exactly one Gray bit (MSB).
  - Every increment bin -> bin+1 (mod 2^WIDTH) changes exactly one bit of gray.
- No X propagation: X on bin yields X only on the affected gray bits. Registered outputs are defined after reset.

Decomposition:
- Shared package gray_pkg: function bin2gray(WIDTH-generic via parameterized function or macro), function gray2bin, constant GRAY_WIDTH_DEFAULT = 4.
- One natural sub-module: gray_decode (combinational Gray-to-binary, parameter WIDTH), used by the checker and reusable elsewhere.

Test Plan:
- Exhaustive combinational sweep, WIDTH=4: bin 0000..1111, 10 ns apart, checking gray equals 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000 at each step.
- Single-bit-change property: increment bin 0..15 and wrap back to 0. Hamming distance between consecutive gray values must be exactly 1, including the 1000 -> 0000 transition.
- Registered path: reset, then en=1 with bin=1010 on one edge. Next cycle gray_q=1111 and out_valid=1. Then en=0 and bin=0101: gray=0111 immediately, while gray_q holds 1111.
- Reset behaviour: capture bin=1111 (gray_q=1000), then assert rst_n low between clock edges. gray_q=0000, out_valid=0 and chk_err=0 immediately. gray still tracks bin during reset.
- Checker: random bin with en toggling for 1000 cycles -> chk_err stays 0. Separately, force gray_q to a wrong value for one cycle -> chk_err=1, and it stays 1 until reset.
- Width scaling, WIDTH=8: bin=11111111 -> gray=10000000; bin=10110100 -> gray=11101110.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults.
// Functions work on 32-bit values; callers size the result.
package gray_pkg;

  localparam int GRAY_WIDTH_DEFAULT = 4;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = ^(g >> i);
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_decode.sv
// Combinational Gray-to-binary decoder.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_decode
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_rt
);

  // Prefix-XOR from the MSB down, written without self-reference
  always_comb begin
    bin_rt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin_rt[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_encoder.sv
// Binary-to-Gray encoder with registered copy
// and a sticky round-trip self-check.
module gray_encoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin,
  input  logic             en,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] gray_q,
  output logic             out_valid,
  output logic             chk_err
);

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] bin_rt;

  assign gray = bin ^ (bin >> 1);

  gray_decode #(
    .WIDTH (WIDTH)
  ) u_dec (
    .gray   (gray_q),
    .bin_rt (bin_rt)
  );

  // Capture the encoding and its source on enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q    <= '0;
      bin_d     <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      gray_q    <= gray;
      bin_d     <= bin;
      out_valid <= 1'b1;
    end
  end

  // Sticky flag when the decoded register disagrees with its source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err <= 1'b0;
    end else if (out_valid && (bin_rt != bin_d)) begin
      chk_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_encoder.sv
// Testbench for gray_encoder: directed steps plus
// random traffic against a reflected-sequence model.
module tb_gray_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] bin = '0;
  logic       en = 1'b0;
  logic [3:0] gray, gray_q;
  logic       out_valid, chk_err;

  logic [7:0] bin8 = '0;
  logic       en8 = 1'b0;
  logic [7:0] gray8, gray_q8;
  logic       out_valid8, chk_err8;

  int checks = 0;
  int errors = 0;

  logic [7:0] seq [256];

  gray_encoder #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin       (bin),
    .en        (en),
    .gray      (gray),
    .gray_q    (gray_q),
    .out_valid (out_valid),
    .chk_err   (chk_err)
  );

  gray_encoder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bin       (bin8),
    .en        (en8),
    .gray      (gray8),
    .gray_q    (gray_q8),
    .out_valid (out_valid8),
    .chk_err   (chk_err8)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Reflect-and-prefix construction of the Gray sequence
  task automatic build_seq();
    int n;
    seq[0] = 8'd0;
    n = 1;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < n; k++) begin
        seq[n + k] = seq[n - 1 - k] | 8'(1 << b);
      end
      n = n * 2;
    end
  endtask

  logic [3:0] tbl [16];
  logic [3:0] prev;
  logic [3:0] exp_q;
  logic       exp_v;
  logic       do_en;

  initial begin
    tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    build_seq();

    #2;
    chk("rst_gray_q", 32'(gray_q), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_chk_err", 32'(chk_err), 32'h0);

    for (int i = 0; i < 16; i++) begin
      bin = 4'(i);
      #10;
      chk("sweep_tbl", 32'(gray), 32'(tbl[i]));
      chk("sweep_model", 32'(gray), 32'(seq[i][3:0]));
    end

    bin = 4'd0;
    #1;
    prev = gray;
    for (int i = 1; i <= 16; i++) begin
      bin = 4'(i % 16);
      #1;
      chk("one_bit", $countones(prev ^ gray), 32'd1);
      prev = gray;
    end

    @(negedge clk);
    rst_n = 1'b1;
    bin = 4'b1010;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("reg_gray_q", 32'(gray_q), 32'hF);
    chk("reg_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    en = 1'b0;
    bin = 4'b0101;
    #1;
    chk("hold_gray", 32'(gray), 32'h7);
    @(posedge clk);
    #1;
    chk("hold_gray_q", 32'(gray_q), 32'hF);

    @(negedge clk);
    bin = 4'hF;
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("cap_ones", 32'(gray_q), 32'h8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gray_q", 32'(gray_q), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_chk_err", 32'(chk_err), 32'h0);
    bin = 4'h6;
    #1;
    chk("rst_track", 32'(gray), 32'h5);
    @(posedge clk);
    #1;
    chk("rst_no_cap", 32'(gray_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    exp_q = '0;
    exp_v = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      bin = 4'($urandom_range(0, 15));
      do_en = 1'($urandom_range(0, 1));
      en = do_en;
      #1;
      chk("rnd_gray", 32'(gray), 32'(seq[bin][3:0]));
      @(posedge clk);
      if (do_en) begin
        exp_q = seq[bin][3:0];
        exp_v = 1'b1;
      end
      #1;
      chk("rnd_gray_q", 32'(gray_q), 32'(exp_q));
      chk("rnd_valid", 32'(out_valid), 32'(exp_v));
      chk("rnd_chk_err", 32'(chk_err), 32'h0);
    end

    @(negedge clk);
    en = 1'b1;
    bin = 4'h3;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    force dut.gray_q = 4'hC;
    @(posedge clk);
    #1;
    chk("inj_err", 32'(chk_err), 32'h1);
    @(negedge clk);
    release dut.gray_q;
    en = 1'b1;
    bin = 4'h9;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("err_sticky", 32'(chk_err), 32'h1);
    chk("err_recap", 32'(gray_q), 32'(seq[9][3:0]));
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("err_cleared", 32'(chk_err), 32'h0);

    bin8 = 8'hFF;
    #1;
    chk("w8_ones", 32'(gray8), 32'h80);
    bin8 = 8'hB4;
    #1;
    chk("w8_b4", 32'(gray8), 32'hEE);
    for (int i = 0; i < 20; i++) begin
      bin8 = 8'($urandom_range(0, 255));
      #1;
      chk("w8_rnd", 32'(gray8), 32'(seq[bin8]));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
